// File: rtl/mul_pkg.sv
// Shared definitions for the RV32M multiply issue controller.
// Op encoding, controller states and per-op decode helpers.
// No logic of its own; imported by the controller and its tests.
package mul_pkg;

  localparam logic [1:0] MUL_OP_MUL    = 2'd0;
  localparam logic [1:0] MUL_OP_MULH   = 2'd1;
  localparam logic [1:0] MUL_OP_MULHSU = 2'd2;
  localparam logic [1:0] MUL_OP_MULHU  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } mul_state_e;

  // Only MUL returns the low half; the three MULH variants return the high half.
  function automatic logic op_is_lo(input logic [1:0] op);
    return op == MUL_OP_MUL;
  endfunction

  function automatic logic op_a_signed(input logic [1:0] op);
    return op != MUL_OP_MULHU;
  endfunction

  function automatic logic op_b_signed(input logic [1:0] op);
    return (op == MUL_OP_MUL) || (op == MUL_OP_MULH);
  endfunction

endpackage

// File: rtl/mul_req_fifo.sv
// Generic DEPTH-entry synchronous FIFO with wrap-bit pointers and a clear input.
// Latency: written entry visible at the head the cycle after the push edge.
// Backpressure: full/empty are registered-state only; push when full and pop when empty are ignored.
module mul_req_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] wr_dat,
  input  logic         pop,
  output logic [W-1:0] rd_dat,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;
  assign rd_dat  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Sequences RV32M multiplies onto the shared 4-cycle non-pipelined multiplier, one op at a time.
// Latency: enqueue at edge t -> issue in t+1 -> multiplier result in t+5 -> res_valid in t+6.
// Backpressure: req_ready drops when the request FIFO is full; a held result blocks further issue until res_ready.
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             mul_in_en,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic             mul_a_signed,
  output logic             mul_b_signed,
  input  logic             mul_idle,
  input  logic             mul_out_en,
  input  logic [31:0]      mul_sum_hi,
  input  logic [31:0]      mul_sum_lo,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [TAG_W-1:0] res_tag,
  output logic [31:0]      res_data
);

  localparam int FW = 2 + 32 + 32 + TAG_W;

  logic [FW-1:0]    head;
  logic [1:0]       head_op;
  logic [TAG_W-1:0] head_tag;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             issue;
  logic             res_cap;

  mul_state_e       state;
  mul_state_e       state_nxt;
  logic             killed;
  logic             killed_nxt;
  logic [1:0]       inf_op;
  logic [TAG_W-1:0] inf_tag;

  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready && !flush;
  assign issue     = (state == IDLE) && !fifo_empty && mul_idle && !flush;

  mul_req_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (flush),
    .push   (push),
    .wr_dat ({req_op, req_rs1, req_rs2, req_tag}),
    .pop    (issue),
    .rd_dat (head),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  assign {head_op, mul_a, mul_b, head_tag} = head;
  assign mul_in_en    = issue;
  assign mul_a_signed = op_a_signed(head_op);
  assign mul_b_signed = op_b_signed(head_op);
  assign res_valid    = (state == HOLD);

  always_comb begin
    state_nxt  = state;
    killed_nxt = killed;
    res_cap    = 1'b0;
    case (state)
      IDLE: begin
        // A late mul_out_en from an op lost to reset lands here and is ignored.
        killed_nxt = 1'b0;
        if (issue) state_nxt = BUSY;
      end
      BUSY: begin
        if (mul_out_en) begin
          killed_nxt = 1'b0;
          if (killed || flush) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = HOLD;
            res_cap   = 1'b1;
          end
        end else if (flush) begin
          killed_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (flush || res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      killed   <= 1'b0;
      inf_op   <= MUL_OP_MUL;
      inf_tag  <= '0;
      res_tag  <= '0;
      res_data <= '0;
    end else begin
      state  <= state_nxt;
      killed <= killed_nxt;
      if (issue) begin
        inf_op  <= head_op;
        inf_tag <= head_tag;
      end
      if (res_cap) begin
        res_tag  <= inf_tag;
        res_data <= op_is_lo(inf_op) ? mul_sum_lo : mul_sum_hi;
      end
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed + randomized bench for mul_issue_ctrl with a 4-cycle multiplier model
// and an order-based result scoreboard computed from RV32M arithmetic.
module tb_mul_issue_ctrl;
  import mul_pkg::*;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             flush = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = 2'd0;
  logic [31:0]      req_rs1 = '0;
  logic [31:0]      req_rs2 = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             mul_in_en;
  logic [31:0]      mul_a, mul_b;
  logic             mul_a_signed, mul_b_signed;
  logic             mul_idle, mul_out_en;
  logic [31:0]      mul_sum_hi, mul_sum_lo;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [TAG_W-1:0] res_tag;
  logic [31:0]      res_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mul_issue_ctrl #(.DEPTH(2), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .mul_in_en(mul_in_en), .mul_a(mul_a), .mul_b(mul_b),
    .mul_a_signed(mul_a_signed), .mul_b_signed(mul_b_signed),
    .mul_idle(mul_idle), .mul_out_en(mul_out_en),
    .mul_sum_hi(mul_sum_hi), .mul_sum_lo(mul_sum_lo),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag), .res_data(res_data)
  );

  always #5 clk = ~clk;

  // Multiplier model: busy for the 4 cycles after a start, result pulse in the last one.
  int          m_cnt = 0;
  logic [63:0] m_prod = '0;
  logic        force_busy = 1'b0;
  logic        force_out = 1'b0;

  function automatic logic [63:0] ext(input logic [31:0] v, input logic s);
    return s ? {{32{v[31]}}, v} : {32'b0, v};
  endfunction

  assign mul_idle   = (m_cnt == 0) && !force_busy;
  assign mul_out_en = (m_cnt == 1) || force_out;
  assign mul_sum_hi = m_prod[63:32];
  assign mul_sum_lo = m_prod[31:0];

  always @(posedge clk) begin
    if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end else if (mul_in_en) begin
      m_cnt  <= 4;
      m_prod <= ext(mul_a, mul_a_signed) * ext(mul_b, mul_b_signed);
    end
  end

  // Architectural RV32M result from the op semantics alone.
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (op)
      MUL_OP_MUL:    p = 64'(sa * sb);
      MUL_OP_MULH:   p = 64'(sa * sb);
      MUL_OP_MULHSU: p = 64'(sa * ub);
      default:       p = {32'b0, a} * {32'b0, b};
    endcase
    return (op == MUL_OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] tag);
    req_valid = 1'b1;
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    req_tag   = tag;
  endtask

  task automatic send(input string nm, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag);
    drive_req(op, a, b, tag);
    #1;
    chk({nm, "_rdy"}, 64'(req_ready), 64'd1);
    nxt();
    req_valid = 1'b0;
  endtask

  task automatic wait_res(input string nm, input int budget);
    int n;
    n = 0;
    #1;
    while (!res_valid && n < budget) begin
      nxt();
      #1;
      n++;
    end
    chk({nm, "_arrive"}, 64'(res_valid), 64'd1);
  endtask

  logic [1:0]  t2_op  [3] = '{MUL_OP_MULH, MUL_OP_MULHU, MUL_OP_MULHSU};
  logic [31:0] t2_a   [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] t2_exp [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
  logic        t2_as  [3] = '{1'b1, 1'b0, 1'b1};
  logic        t2_bs  [3] = '{1'b1, 1'b0, 1'b0};

  logic [35:0]      q [$];
  logic [35:0]      e;
  logic [TAG_W-1:0] rtag;
  logic [31:0]      a0, b0, a1, b1, a2, b2, hold_d;
  int               prev;

  initial begin
    // Reset values
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_tag", 64'(res_tag), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_in_en", 64'(mul_in_en), 64'd0);
    rst_n = 1'b1;
    nxt();

    // MUL 7 * -3, exact latency
    send("t1", MUL_OP_MUL, 32'd7, 32'hFFFF_FFFD, 4'd3);
    #1;
    chk("t1_in_en", 64'(mul_in_en), 64'd1);
    chk("t1_signs", 64'({mul_a_signed, mul_b_signed}), 64'd3);
    chk("t1_mul_a", 64'(mul_a), 64'd7);
    for (int k = 2; k <= 5; k++) begin
      nxt();
      #1;
      chk("t1_early_valid", 64'(res_valid), 64'd0);
    end
    chk("t1_out_en_t5", 64'(mul_out_en), 64'd1);
    nxt();
    #1;
    chk("t1_valid_t6", 64'(res_valid), 64'd1);
    chk("t1_data", 64'(res_data), 64'hFFFF_FFEB);
    chk("t1_tag", 64'(res_tag), 64'd3);
    nxt();
    #1;
    chk("t1_one_cycle", 64'(res_valid), 64'd0);

    // High-half variants and their signedness
    for (int i = 0; i < 3; i++) begin
      send($sformatf("t2_%0d", i), t2_op[i], t2_a[i], 32'hFFFF_FFFF & t2_a[i], 4'(i + 4));
      #1;
      chk($sformatf("t2_%0d_in_en", i), 64'(mul_in_en), 64'd1);
      chk($sformatf("t2_%0d_asign", i), 64'(mul_a_signed), 64'(t2_as[i]));
      chk($sformatf("t2_%0d_bsign", i), 64'(mul_b_signed), 64'(t2_bs[i]));
      wait_res($sformatf("t2_%0d", i), 10);
      chk($sformatf("t2_%0d_data", i), 64'(res_data), 64'(t2_exp[i]));
      chk($sformatf("t2_%0d_ref", i), 64'(res_data), 64'(ref_res(t2_op[i], t2_a[i], t2_a[i])));
      nxt();
    end

    // Full FIFO, held result, in-order drain with 6-cycle spacing
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    res_ready = 1'b0;
    force_busy = 1'b1;
    send("t3_a", MUL_OP_MUL, a0, b0, 4'd1);
    send("t3_b", MUL_OP_MULH, a1, b1, 4'd2);
    drive_req(MUL_OP_MULHSU, a2, b2, 4'd3);
    #1;
    chk("t3_full_rdy", 64'(req_ready), 64'd0);
    chk("t3_busy_no_issue", 64'(mul_in_en), 64'd0);
    nxt();
    force_busy = 1'b0;
    #1;
    chk("t3_issue", 64'(mul_in_en), 64'd1);
    chk("t3_issue_a", 64'(mul_a), 64'(a0));
    chk("t3_still_full", 64'(req_ready), 64'd0);
    nxt();
    #1;
    chk("t3_rdy_after_pop", 64'(req_ready), 64'd1);
    nxt();
    req_valid = 1'b0;
    wait_res("t3_a", 10);
    chk("t3_a_tag", 64'(res_tag), 64'd1);
    chk("t3_a_data", 64'(res_data), 64'(ref_res(MUL_OP_MUL, a0, b0)));
    hold_d = res_data;
    for (int k = 0; k < 10; k++) begin
      nxt();
      #1;
      chk("t3_hold_valid", 64'(res_valid), 64'd1);
      chk("t3_hold_data", 64'({res_tag, res_data}), 64'({4'd1, hold_d}));
      chk("t3_hold_no_issue", 64'(mul_in_en), 64'd0);
    end
    res_ready = 1'b1;
    prev = cyc;
    nxt();
    wait_res("t3_b", 10);
    chk("t3_b_tag", 64'(res_tag), 64'd2);
    chk("t3_b_data", 64'(res_data), 64'(ref_res(MUL_OP_MULH, a1, b1)));
    chk("t3_b_spacing", 64'(cyc - prev), 64'd6);
    prev = cyc;
    nxt();
    wait_res("t3_c", 10);
    chk("t3_c_tag", 64'(res_tag), 64'd3);
    chk("t3_c_data", 64'(res_data), 64'(ref_res(MUL_OP_MULHSU, a2, b2)));
    chk("t3_c_spacing", 64'(cyc - prev), 64'd6);
    nxt();

    // Flush while busy with one op queued
    send("t4_5", MUL_OP_MUL, $urandom, $urandom, 4'd5);
    drive_req(MUL_OP_MULH, $urandom, $urandom, 4'd6);
    #1;
    chk("t4_issue", 64'(mul_in_en), 64'd1);
    chk("t4_rdy6", 64'(req_ready), 64'd1);
    nxt();
    req_valid = 1'b0;
    nxt();
    flush = 1'b1;
    #1;
    chk("t4_no_issue_flush", 64'(mul_in_en), 64'd0);
    nxt();
    flush = 1'b0;
    #1;
    chk("t4_rdy", 64'(req_ready), 64'd1);
    for (int k = 0; k < 10; k++) begin
      nxt();
      #1;
      chk("t4_quiet", 64'({res_valid, mul_in_en}), 64'd0);
    end
    a0 = $urandom; b0 = $urandom;
    send("t4_7", MUL_OP_MULHU, a0, b0, 4'd7);
    wait_res("t4_7", 10);
    chk("t4_7_tag", 64'(res_tag), 64'd7);
    chk("t4_7_data", 64'(res_data), 64'(ref_res(MUL_OP_MULHU, a0, b0)));
    nxt();

    // Flush coinciding with the multiplier result
    send("t5a", MUL_OP_MUL, $urandom, $urandom, 4'd8);
    prev = 0;
    #1;
    while (!mul_out_en && prev < 10) begin
      nxt();
      #1;
      prev++;
    end
    chk("t5a_out_en", 64'(mul_out_en), 64'd1);
    flush = 1'b1;
    nxt();
    flush = 1'b0;
    for (int k = 0; k < 6; k++) begin
      nxt();
      #1;
      chk("t5a_quiet", 64'({res_valid, mul_in_en}), 64'd0);
    end

    // Flush while holding a result
    res_ready = 1'b0;
    send("t5b", MUL_OP_MULHSU, $urandom, $urandom, 4'd9);
    wait_res("t5b", 10);
    flush = 1'b1;
    nxt();
    flush = 1'b0;
    res_ready = 1'b1;
    #1;
    chk("t5b_dropped", 64'(res_valid), 64'd0);

    // Flush with a simultaneous request
    flush = 1'b1;
    drive_req(MUL_OP_MUL, 32'd1, 32'd1, 4'd10);
    nxt();
    flush = 1'b0;
    req_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      nxt();
      #1;
      chk("t5c_not_queued", 64'({res_valid, mul_in_en}), 64'd0);
    end
    send("t5d", MUL_OP_MUL, 32'd3, 32'd5, 4'd11);
    wait_res("t5d", 10);
    chk("t5d_res", 64'({res_tag, res_data}), 64'({4'd11, 32'd15}));
    nxt();

    // Reset while busy; multiplier keeps running
    send("t6_12", MUL_OP_MULH, $urandom, $urandom, 4'd12);
    nxt();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tagdata", 64'({res_tag, res_data}), 64'd0);
    chk("t6_rst_ctrl", 64'({res_valid, req_ready, mul_in_en}), 64'b010);
    nxt();
    rst_n = 1'b1;
    force_busy = 1'b1;
    a0 = $urandom; b0 = $urandom;
    send("t6_13", MUL_OP_MULHSU, a0, b0, 4'd13);
    force_out = 1'b1;
    #1;
    chk("t6_wait_idle0", 64'({res_valid, mul_in_en}), 64'd0);
    nxt();
    force_out = 1'b0;
    #1;
    chk("t6_wait_idle1", 64'({res_valid, mul_in_en}), 64'd0);
    nxt();
    force_busy = 1'b0;
    #1;
    chk("t6_issue_after_idle", 64'({res_valid, mul_in_en}), 64'd1);
    nxt();
    wait_res("t6_13", 10);
    chk("t6_13_res", 64'({res_tag, res_data}), 64'({4'd13, ref_res(MUL_OP_MULHSU, a0, b0)}));
    nxt();

    // Randomized traffic against the queue model
    rtag = '0;
    for (int n = 0; n < 400; n++) begin
      nxt();
      flush     = ($urandom_range(0, 39) == 0);
      res_ready = flush ? 1'b0 : ($urandom_range(0, 2) != 0);
      req_valid = 1'($urandom_range(0, 1));
      req_op    = 2'($urandom_range(0, 3));
      req_rs1   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      req_rs2   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      req_tag   = rtag;
      #1;
      if (res_valid && res_ready) begin
        if (q.size() == 0) begin
          chk("rnd_spurious", 64'(res_valid), 64'd0);
        end else begin
          e = q.pop_front();
          chk("rnd_tag", 64'(res_tag), 64'(e[35:32]));
          chk("rnd_data", 64'(res_data), 64'(e[31:0]));
        end
      end
      if (flush) begin
        q.delete();
      end else if (req_valid && req_ready) begin
        q.push_back({rtag, ref_res(req_op, req_rs1, req_rs2)});
        rtag++;
      end
    end
    req_valid = 1'b0;
    flush = 1'b0;
    res_ready = 1'b1;
    for (int n = 0; n < 100 && q.size() != 0; n++) begin
      nxt();
      #1;
      if (res_valid) begin
        e = q.pop_front();
        chk("drain_tag", 64'(res_tag), 64'(e[35:32]));
        chk("drain_data", 64'(res_data), 64'(e[31:0]));
      end
    end
    chk("rnd_drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
